// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder: one full-adder cell plus a carry FF,
//            LSB-first, with a one-cycle done pulse on completion.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] shs_q, shs_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             w_fa_s;
    logic             w_fa_c;
    logic [WIDTH-1:0] w_shs_next;

    // The single reused full-adder cell.
    assign w_fa_s     = sha_q[0] ^ shb_q[0] ^ carry_q;
    assign w_fa_c     = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);
    assign w_shs_next = {w_fa_s, shs_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            shs_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shs_q   <= shs_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        shs_d   = shs_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sha_d   = a;
                    shb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    shs_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                shs_d   = w_shs_next;
                sha_d   = {1'b0, sha_q[WIDTH-1:1]};
                shb_d   = {1'b0, shb_q[WIDTH-1:1]};
                carry_d = w_fa_c;
                cnt_d   = cnt_q + CW'(1);
                // Outputs only move here, so partial sums never leak out.
                if (cnt_q == C_LAST_BIT) begin
                    sum_d   = w_shs_next;
                    cout_d  = w_fa_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q == S_ADD);
    assign done = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed, table-driven bench for serial_adder (WIDTH=8 and 3).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] sum;
    logic       cout, busy, done;

    logic       start3;
    logic [2:0] a3, b3;
    logic       cin3;
    logic [2:0] sum3;
    logic       cout3, busy3, done3;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    serial_adder #(.WIDTH(8), .CW(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .sum(sum), .cout(cout), .busy(busy), .done(done)
    );

    serial_adder #(.WIDTH(3), .CW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .sum(sum3), .cout(cout3), .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        string      name;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int         n;
        int         busy_cnt;
        logic       leak;
        logic       overlap;
        logic [7:0] prev_sum;
        start = 1'b1; a = v.a; b = v.b; cin = v.cin;
        tick();
        start = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin;
        n = 0; busy_cnt = 0; leak = 1'b0; overlap = 1'b0; prev_sum = sum;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (busy && done) overlap = 1'b1;
            if (sum !== prev_sum) leak = 1'b1;
            tick();
            n++;
        end
        chk({v.name, "_latency"}, n, 8);
        chk({v.name, "_busy_cycles"}, busy_cnt, 8);
        chk({v.name, "_partial_leak"}, {31'd0, leak}, 0);
        chk({v.name, "_overlap"}, {31'd0, overlap | (busy & done)}, 0);
        chk({v.name, "_sum"}, {24'd0, sum}, {24'd0, v.exp_sum});
        chk({v.name, "_cout"}, {31'd0, cout}, {31'd0, v.exp_cout});
        tick();
        chk({v.name, "_done_one_cycle"}, {31'd0, done}, 0);
    endtask

    vec_t vecs[8];

    initial begin
        int t_done[3];
        int nd;
        int n;
        logic [3:0] exp3;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "v5A_3C"};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "vFF_01"};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "vFF_FF_c1"};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "v00_00_c1"};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "v80_80"};
        vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, "v7F_00_c1"};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, "vA5_5A"};
        vecs[7] = '{8'hC3, 8'h3D, 1'b1, 8'h01, 1'b1, "vC3_3D_c1"};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        tick(); tick();
        chk("reset_sum", {24'd0, sum}, 0);
        chk("reset_cout", {31'd0, cout}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i]);
        end

        // Restarts during ADD and DONE must be ignored.
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; a = 8'hAA; b = 8'h55;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin tick(); n++; end
        chk("ignore_latency", n + 3, 8);
        chk("ignore_sum", {24'd0, sum}, 32'h30);
        chk("ignore_cout", {31'd0, cout}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignore_done_pulse", {31'd0, done}, 0);
        chk("ignore_in_done_busy", {31'd0, busy}, 0);
        tick(); tick();
        chk("ignore_idle_busy", {31'd0, busy}, 0);
        chk("ignore_sum_hold", {24'd0, sum}, 32'h30);
        run_op('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, "after_ignore"});

        // Asynchronous reset mid-addition.
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sum", {24'd0, sum}, 0);
        chk("abort_cout", {31'd0, cout}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) nd++;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_sum_after", {24'd0, sum}, 0);
        run_op('{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "after_abort"});

        // Start held high: one completion every WIDTH+2 cycles.
        start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        nd = 0; n = 0;
        while (nd < 3 && n < 60) begin
            tick();
            n++;
            if (done) begin
                t_done[nd] = cyc;
                nd++;
            end
        end
        start = 1'b0;
        chk("stream_done_count", nd, 3);
        if (nd == 3) begin
            chk("stream_spacing_1", t_done[1] - t_done[0], 10);
            chk("stream_spacing_2", t_done[2] - t_done[1], 10);
        end
        chk("stream_sum", {24'd0, sum}, 3);
        tick(); tick();

        // WIDTH=3 exhaustive sweep.
        for (int i = 0; i < 128; i++) begin
            a3 = i[6:4]; b3 = i[3:1]; cin3 = i[0];
            exp3 = {1'b0, a3} + {1'b0, b3} + {3'd0, cin3};
            start3 = 1'b1;
            tick();
            start3 = 1'b0;
            n = 0;
            while (!done3 && n < 20) begin tick(); n++; end
            chk($sformatf("w3_%0d", i), {28'd0, cout3, sum3}, {28'd0, exp3});
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
